// File: rtl/assoc_cache.sv
// Set-associative, write-through, write-allocate cache with per-set round-robin replacement.
// Define CACHE_PERF_CNT_EN to add hit/miss counters. SETS_LOG2 and WORDS_LOG2 must be >= 1.
module assoc_cache #(
  parameter int SETS_LOG2  = 5,
  parameter int WAYS       = 2,
  parameter int WORDS_LOG2 = 2
) (
`ifdef CACHE_PERF_CNT_EN
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt,
`endif
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic        o_busy,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [3:0]  i_req_mask,
  input  logic [31:0] i_req_wdata,
  output logic [31:0] o_res_rdata
);
  // state | meaning
  // IDLE  | tag lookup; read hits answered combinationally
  // FILL  | fetching the line into the victim way, one read outstanding
  // WRITE | write-through of the merged word; cache word updated on accept
  localparam int O     = WORDS_LOG2 + 2;
  localparam int S     = SETS_LOG2;
  localparam int T     = 32 - O - S;
  localparam int SETS  = 1 << S;
  localparam int WORDS = 1 << WORDS_LOG2;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  state_t state_q, state_d;

  logic [31:0]     data_q  [SETS][WAYS][WORDS];
  logic [T-1:0]    tag_q   [SETS][WAYS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WW-1:0]   ptr_q   [SETS];

  logic [31:2]           addr_q;
  logic                  wen_q;
  logic                  wait_q;
  logic [WW-1:0]         way_q;
  logic [WORDS_LOG2-1:0] cnt_q;

  logic [S-1:0]          req_idx, op_idx;
  logic [T-1:0]          req_tag, op_tag;
  logic [WORDS_LOG2-1:0] req_word, op_word;
  logic                  hit;
  logic [WW-1:0]         hit_way, victim;
  logic                  fill_beat, fill_last;
  logic [31:0]           cur_word, merged;
  logic                  unused_addr;

  assign req_idx     = i_req_addr[O+S-1:O];
  assign req_tag     = i_req_addr[31:O+S];
  assign req_word    = i_req_addr[O-1:2];
  assign op_idx      = addr_q[O+S-1:O];
  assign op_tag      = addr_q[31:O+S];
  assign op_word     = addr_q[O-1:2];
  assign unused_addr = ^i_req_addr[1:0];

  assign fill_beat = (state_q == FILL) && wait_q && i_mem_valid;
  assign fill_last = fill_beat && (cnt_q == '1);
  assign cur_word  = data_q[op_idx][way_q][op_word];

  function automatic logic [WW-1:0] next_way(input logic [WW-1:0] w);
    return (w == WW'(WAYS - 1)) ? '0 : w + 1'b1;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
    // Lowest-index invalid way wins; otherwise the round-robin pointer.
    victim = ptr_q[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) victim = WW'(w);
    end
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = i_req_mask[b] ? i_req_wdata[8*b +: 8] : cur_word[8*b +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    o_busy      = 1'b0;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_res_rdata = '0;
    unique case (state_q)
      IDLE: begin
        if (i_req_ren && hit) begin
          o_res_rdata = data_q[req_idx][hit_way][req_word];
        end else if (i_req_ren || i_req_wen) begin
          o_busy  = 1'b1;
          state_d = hit ? WRITE : FILL;
        end
      end
      FILL: begin
        o_busy     = 1'b1;
        o_mem_ren  = !wait_q;
        o_mem_addr = {addr_q[31:O], cnt_q, 2'b00};
        if (fill_last) begin
          if (wen_q) begin
            state_d = WRITE;
          end else begin
            state_d     = IDLE;
            o_busy      = 1'b0;
            o_res_rdata = (op_word == cnt_q) ? i_mem_rdata : data_q[op_idx][way_q][op_word];
          end
        end
      end
      WRITE: begin
        o_busy      = !i_mem_ready;
        o_mem_wen   = 1'b1;
        o_mem_addr  = {addr_q, 2'b00};
        o_mem_wdata = merged;
        if (i_mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_rst) begin
      o_busy      = 1'b0;
      o_mem_ren   = 1'b0;
      o_mem_wen   = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_res_rdata = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wait_q  <= 1'b0;
      way_q   <= '0;
      cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (i_req_ren && hit) begin
            ptr_q[req_idx] <= next_way(hit_way);
          end else if (i_req_ren || i_req_wen) begin
            addr_q <= i_req_addr[31:2];
            wen_q  <= i_req_wen;
            wait_q <= 1'b0;
            cnt_q  <= '0;
            if (hit) begin
              way_q <= hit_way;
            end else begin
              way_q                   <= victim;
              valid_q[req_idx][victim] <= 1'b0;
            end
          end
        end
        FILL: begin
          if (!wait_q && i_mem_ready) begin
            wait_q <= 1'b1;
          end else if (fill_beat) begin
            wait_q <= 1'b0;
            cnt_q  <= cnt_q + 1'b1;
            if (fill_last) begin
              valid_q[op_idx][way_q] <= 1'b1;
              ptr_q[op_idx]          <= next_way(way_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; validity alone decides what is usable.
  always_ff @(posedge i_clk) begin
    if (!i_rst && fill_beat) begin
      data_q[op_idx][way_q][cnt_q] <= i_mem_rdata;
      if (fill_last) tag_q[op_idx][way_q] <= op_tag;
    end
    if (!i_rst && (state_q == WRITE) && i_mem_ready) begin
      data_q[op_idx][way_q][op_word] <= merged;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if ((state_q == IDLE) && (i_req_ren || i_req_wen)) begin
      if (hit) begin
        if (o_hit_cnt != '1) o_hit_cnt <= o_hit_cnt + 1'b1;
      end else begin
        if (o_miss_cnt != '1) o_miss_cnt <= o_miss_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: directed scenarios plus random traffic checked against a
// line-residency model whose data comes straight from a memory model (write-through).
module tb_assoc_cache;
  localparam int O          = 4;
  localparam int SETS       = 32;
  localparam int WAYS       = 2;
  localparam int WORDS      = 4;
  localparam int LINE_BYTES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ready, mem_valid;
  logic [31:0] mem_rdata;
  logic [31:0] o_mem_addr, o_mem_wdata, o_res_rdata;
  logic        o_mem_ren, o_mem_wen, o_busy;
  logic [31:0] req_addr, req_wdata;
  logic        req_ren, req_wen;
  logic [3:0]  req_mask;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  assoc_cache #(.SETS_LOG2(5), .WAYS(WAYS), .WORDS_LOG2(2)) dut (
`ifdef CACHE_PERF_CNT_EN
    .o_hit_cnt(hit_cnt),
    .o_miss_cnt(miss_cnt),
`endif
    .i_clk(clk),
    .i_rst(rst),
    .i_mem_ready(mem_ready),
    .o_mem_addr(o_mem_addr),
    .o_mem_ren(o_mem_ren),
    .o_mem_wen(o_mem_wen),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(mem_rdata),
    .i_mem_valid(mem_valid),
    .o_busy(o_busy),
    .i_req_addr(req_addr),
    .i_req_ren(req_ren),
    .i_req_wen(req_wen),
    .i_req_mask(req_mask),
    .i_req_wdata(req_wdata),
    .o_res_rdata(o_res_rdata)
  );

  int tests = 0;
  int fails = 0;

  // memory model: untouched words read back as their own address
  logic [31:0] mem_m [int unsigned];
  // residency model: line base address per set/way
  int unsigned lb [SETS][WAYS];
  bit          lv [SETS][WAYS];
  int          ptr_m [SETS];
  int          hits_m, misses_m;

  int          pend;
  logic [31:0] pend_data;
  int          ready_pct, ready_block, lat_min, lat_max;
  bit          prev_stall;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      ptr_m[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        lv[s][w] = 1'b0;
        lb[s][w] = 0;
      end
    end
    hits_m = 0;
    misses_m = 0;
  endtask

  task automatic drive_mem();
    mem_valid = 1'b0;
    mem_rdata = $urandom;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_valid = 1'b1;
        mem_rdata = pend_data;
      end
    end
    if (ready_block > 0) begin
      mem_ready = 1'b0;
      ready_block--;
    end else begin
      mem_ready = ($urandom_range(99) < ready_pct);
    end
  endtask

  task automatic sample_mem();
    if (o_mem_ren && mem_ready) begin
      chk("one_outstanding", 32'(pend), 0);
      pend      = $urandom_range(lat_max, lat_min);
      pend_data = mem_rd(o_mem_addr);
    end
    prev_stall = o_mem_ren && !mem_ready;
    prev_addr  = o_mem_addr;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  32'(o_busy), 0);
    chk({tag, "_ren"},   32'(o_mem_ren), 0);
    chk({tag, "_wen"},   32'(o_mem_wen), 0);
    chk({tag, "_addr"},  o_mem_addr, 0);
    chk({tag, "_wdata"}, o_mem_wdata, 0);
    chk({tag, "_rdata"}, o_res_rdata, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive_mem();
      #2;
      chk("idle_busy", 32'(o_busy), 0);
      sample_mem();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Issue one request at a negedge and follow it to completion; returns at a negedge.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d, output bit hit_o,
                        output logic [31:0] rdata_o, output logic [31:0] wdata_o);
    int s, mway, victim, reads, cyc;
    bit mhit;
    logic [31:0] base, cur, merged;
    s    = int'((a >> O) % SETS);
    base = a & ~32'(LINE_BYTES - 1);
    mhit = 1'b0;
    mway = 0;
    for (int w = 0; w < WAYS; w++)
      if (lv[s][w] && lb[s][w] == base) begin
        mhit = 1'b1;
        mway = w;
      end
    victim = ptr_m[s];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!lv[s][w]) victim = w;
    cur = mem_rd(a);
    for (int b = 0; b < 4; b++) merged[8*b +: 8] = m[b] ? d[8*b +: 8] : cur[8*b +: 8];
    req_addr  = a;
    req_ren   = !wr;
    req_wen   = wr;
    req_mask  = m;
    req_wdata = d;
    rdata_o   = '0;
    wdata_o   = '0;
    reads     = 0;
    cyc       = 0;
    drive_mem();
    #2;
    chk("busy_first", 32'(o_busy), 32'(wr || !mhit));
    forever begin
      chk("ren_wen_excl", 32'(o_mem_ren && o_mem_wen), 0);
      if (prev_stall) begin
        chk("ren_held", 32'(o_mem_ren), 1);
        chk("addr_held", o_mem_addr, prev_addr);
      end
      if (o_mem_ren && mem_ready) begin
        chk("fill_addr", o_mem_addr, base + 32'(4 * reads));
        reads++;
      end
      if (!wr) chk("no_wen_on_read", 32'(o_mem_wen), 0);
      if (o_busy) chk("rdata_zero_busy", o_res_rdata, 0);
      if (o_mem_wen && mem_ready) chk("busy_drop_on_write", 32'(o_busy), 0);
      if (!o_busy) begin
        if (wr) begin
          chk("wen_done", 32'(o_mem_wen && mem_ready), 1);
          chk("waddr", o_mem_addr, a);
          chk("wdata", o_mem_wdata, merged);
          wdata_o  = o_mem_wdata;
          mem_m[a] = merged;
        end else begin
          chk("rdata", o_res_rdata, cur);
          rdata_o = o_res_rdata;
        end
        chk("fill_reads", 32'(reads), mhit ? 0 : WORDS);
        sample_mem();
        break;
      end
      sample_mem();
      @(posedge clk);
      @(negedge clk);
      drive_mem();
      #2;
      cyc++;
      if (cyc > 400) begin
        tests++;
        fails++;
        $display("FAIL timeout: request 0x%08h still busy after %0d cycles", a, cyc);
        break;
      end
    end
    hit_o = (reads == 0);
    @(posedge clk);
    if (mhit) begin
      hits_m++;
      if (!wr) ptr_m[s] = (mway + 1) % WAYS;
    end else begin
      misses_m++;
      lb[s][victim] = base;
      lv[s][victim] = 1'b1;
      ptr_m[s]      = (victim + 1) % WAYS;
    end
    @(negedge clk);
    req_ren = 1'b0;
    req_wen = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    logic [31:0] rd, wd;
    int tag_tab [4];
    tag_tab = '{1, 2, 3, 5};
    rst = 1'b1;
    req_addr = '0; req_ren = 1'b0; req_wen = 1'b0; req_mask = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    pend = 0; prev_stall = 1'b0; prev_addr = '0; ready_block = 0;
    ready_pct = 100; lat_min = 2; lat_max = 2;
    model_reset();

    repeat (2) @(negedge clk);
    #2 chk_zero("in_reset");
    @(negedge clk);
    rst = 1'b0;
    drive_mem();
    #2 chk_zero("after_reset");
    sample_mem();
    @(posedge clk);
    @(negedge clk);

    // read miss then hits on the same line
    do_req(1'b0, 32'h0000_1004, 4'h0, 32'h0, h, rd, wd);
    chk("miss_1004_hit", 32'(h), 0);
    chk("miss_1004_rdata", rd, 32'h0000_1004);
    do_req(1'b0, 32'h0000_1008, 4'h0, 32'h0, h, rd, wd);
    chk("hit_1008_hit", 32'(h), 1);
    chk("hit_1008_rdata", rd, 32'h0000_1008);

    // write hit with partial mask, then mask 0000
    do_req(1'b1, 32'h0000_1008, 4'b0011, 32'hAAAA_BBBB, h, rd, wd);
    chk("wr_1008_wdata", wd, 32'h0000_BBBB);
    do_req(1'b0, 32'h0000_1008, 4'h0, 32'h0, h, rd, wd);
    chk("rd_after_wr", rd, 32'h0000_BBBB);
    do_req(1'b1, 32'h0000_1008, 4'b0000, 32'hFFFF_FFFF, h, rd, wd);
    chk("wr_mask0_wdata", wd, 32'h0000_BBBB);

    // two-way replacement in set 3
    do_req(1'b0, 32'h0000_2030, 4'h0, 32'h0, h, rd, wd);
    do_req(1'b0, 32'h0000_4030, 4'h0, 32'h0, h, rd, wd);
    do_req(1'b0, 32'h0000_2030, 4'h0, 32'h0, h, rd, wd);
    chk("setA_hit", 32'(h), 1);
    do_req(1'b0, 32'h0000_6030, 4'h0, 32'h0, h, rd, wd);
    chk("setC_miss", 32'(h), 0);
    do_req(1'b0, 32'h0000_2034, 4'h0, 32'h0, h, rd, wd);
    chk("setA_still_hit", 32'(h), 1);
    do_req(1'b0, 32'h0000_4038, 4'h0, 32'h0, h, rd, wd);
    chk("setB_evicted", 32'(h), 0);

    // memory stalls during fill
    ready_block = 6;
    do_req(1'b0, 32'h0000_3008, 4'h0, 32'h0, h, rd, wd);
    chk("stall_fill_rdata", rd, 32'h0000_3008);

    // reset in the middle of a fill
    req_addr = 32'h0000_5000;
    req_ren  = 1'b1;
    repeat (3) begin
      drive_mem();
      #2;
      sample_mem();
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1; req_ren = 1'b0; pend = 0; mem_valid = 1'b0; mem_ready = 1'b0;
    #2 chk_zero("mid_fill_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_stall = 1'b0;
    model_reset();
    drive_mem();
    #2 chk_zero("after_mid_reset");
    sample_mem();
    @(posedge clk);
    @(negedge clk);
    do_req(1'b0, 32'h0000_5000, 4'h0, 32'h0, h, rd, wd);
    chk("aborted_line_misses", 32'(h), 0);
    do_req(1'b0, 32'h0000_1004, 4'h0, 32'h0, h, rd, wd);
    chk("old_line_misses", 32'(h), 0);
    chk("old_line_rdata", rd, 32'h0000_1004);

    // random traffic over a small address pool to force hits and evictions
    ready_pct = 75; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = (32'(tag_tab[$urandom_range(3)]) << 9) | (32'($urandom_range(3)) << 4)
          | (32'($urandom_range(3)) << 2);
      do_req($urandom_range(2) == 0, a, 4'($urandom_range(15)), $urandom, h, rd, wd);
      if ($urandom_range(4) == 0) idle(1);
    end

`ifdef CACHE_PERF_CNT_EN
    chk("hit_cnt", hit_cnt, 32'(hits_m));
    chk("miss_cnt", miss_cnt, 32'(misses_m));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
